// File: rtl/multi_cycle_chunk_adder.sv
// Multi-cycle chunked adder/subtractor.
// Adds a + b + carryin (or a - b - carryin) over WIDTH/CHUNK cycles, one
// CHUNK-bit ripple slice per cycle, LSB slice first. Results and flags are
// registered and updated only in the DONE cycle, so they hold between DONEs.

// One full-adder cell built from explicit gates; CHUNK of these form the slice.
module mcca_fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    logic axb;
    logic gen;
    logic prop;

    assign axb  = a_i ^ b_i;
    assign s_o  = axb ^ c_i;
    assign gen  = a_i & b_i;
    assign prop = axb & c_i;
    assign c_o  = gen | prop;
endmodule

module multi_cycle_chunk_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
    input  logic             subtract,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    // Operand registers shift right by CHUNK each RUN cycle so the active
    // slice is always in the low CHUNK bits.
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    // Slices enter at the top and shift down; after N slices it is aligned.
    logic [WIDTH-1:0] acc_q, acc_d;
    // Operand sign bits are kept apart because the shifting discards them.
    logic             amsb_q, amsb_d;
    logic             bmsb_q, bmsb_d;

    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic             accept;
    logic             last;
    logic [CHUNK:0]   rc;
    logic [CHUNK-1:0] slice;

    assign accept = start && ((state_q == IDLE) || (state_q == DONE));
    assign last   = (state_q == RUN) && (cnt_q == CW'(N - 1));

    // Ripple chain for the current slice.
    assign rc[0] = carry_q;
    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        mcca_fa_cell u_fa (
            .a_i (a_q[i]),
            .b_i (b_q[i]),
            .c_i (rc[i]),
            .s_o (slice[i]),
            .c_o (rc[i+1])
        );
    end

    // Next-state logic: accept moves to RUN, last slice moves to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = accept ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next-state: latch operands on accept, process a slice in RUN,
    // publish results on the final slice.
    always_comb begin
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        amsb_d  = amsb_q;
        bmsb_d  = bmsb_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        if (accept) begin
            a_d     = a;
            b_d     = subtract ? ~b : b;
            carry_d = subtract ^ carryin;
            cnt_d   = '0;
            amsb_d  = a[WIDTH-1];
            bmsb_d  = subtract ? ~b[WIDTH-1] : b[WIDTH-1];
        end else if (state_q == RUN) begin
            a_d     = a_q >> CHUNK;
            b_d     = b_q >> CHUNK;
            acc_d   = (acc_q >> CHUNK) | (WIDTH'(slice) << (WIDTH - CHUNK));
            carry_d = rc[CHUNK];
            cnt_d   = cnt_q + 1'b1;
            if (last) begin
                sum_d  = acc_d;
                cout_d = rc[CHUNK];
                ovf_d  = (amsb_q == bmsb_q) && (acc_d[WIDTH-1] != amsb_q);
                zero_d = (acc_d == '0);
            end
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            amsb_q  <= amsb_d;
            bmsb_q  <= bmsb_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign sum      = sum_q;
    assign carryout = cout_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;
endmodule
